exec_ctrl: RTL and testbench
============================

Name: exec_ctrl

Overview:
Pipelined execute-stage controller for the Y86-64 core. It accepts one decoded instruction per cycle over a valid/ready handshake and sequences the shared alu. It owns the condition-code register (ZF/SF/OF) and evaluates Cnd for jXX/cmovXX. Results are held in a single-entry E->M output register, with flush, CC-inhibit and halt handling.

Parameters:
W, 64, datapath width (valA/valB/valC/valE)
RNONE, 4'hF, register ID meaning "no destination"

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  controller can accept this cycle
in_icode  in  4  instruction code
in_ifun  in  4  function code
in_valA  in  W  signed operand A
in_valB  in  W  signed operand B
in_valC  in  W  signed constant
in_dstE  in  4  destination register for valE
flush  in  1  squash (branch mispredict); drops current accept and output entry
cc_inhibit  in  1  later-stage exception; blocks CC update
out_valid  out  1  E->M entry valid
out_ready  in  1  memory stage consumes entry
out_icode  out  4  registered icode
out_valE  out  W  registered ALU result
out_valA  out  W  registered valA pass-through
out_dstE  out  4  registered dstE (RNONE if cmov not taken)
out_Cnd  out  1  registered condition
out_stat  out  2  0=AOK, 1=HLT, 2=INS
cc_zf, cc_sf, cc_of  out  1 each  current CC register

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_* data=0, out_dstE=RNONE, out_stat=AOK, CC: ZF=1, SF=0, OF=0, state=RUN.
- in_ready = (state==RUN) && (!out_valid || out_ready). accept = in_valid && in_ready && !flush.
- Latency: 1 cycle. Accepted instruction appears on out_* the next cycle. Throughput is 1/cycle while out_ready=1.
- Output register:
  - flush=1: out_valid<=0.
  - else accept: load output register, out_valid<=1.
  - else out_ready: out_valid<=0.
  - else hold.
- ALU operand/control per icode (alu control 00 add, 01 sub B-A form, 10 and, 11 xor):
  - cmovXX(2): 0+valA.
  - irmovq(3): valC+0.
  - rmmovq(4)/mrmovq(5): valB+valC.
  - OPq(6): add valA+valB; sub valB-valA; and; xor.
  - call(8)/pushq(A): valB-8.
  - ret(9)/popq(B): valB+8.
  - All other icodes: valE=0.
  - All arithmetic wraps mod 2^W.
- CC computation (OPq only):
  - ZF = (result==0); SF = result[W-1].
  - OF for add: sign(valA)==sign(valB) && sign(S)!=sign(valA).
  - OF for sub: sign(valB)!=sign(valA) && sign(S)!=sign(valB).
  - OF for and/xor: 0.
- CC update: CC is written on the accept edge only when icode==6, ifun<=3, and cc_inhibit=0. It is not written on flush.
- Cnd evaluation uses CC before the instruction's own update, so a back-to-back OPq followed by jXX/cmov sees the OPq's flags.
  - ifun 0: always.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&&!ZF.
  - ifun>6: INS.
  - Cnd=0 for non-jXX/cmov.
  - cmov with Cnd=0: out_dstE=RNONE.
- Status:
  - icode>0xB, or OPq ifun>3, or jXX/cmov ifun>6: INS, with valE=0, no CC write.
  - icode 0 (halt): HLT.
- FSM:
  - RUN: accepting HLT or INS moves to HALTED.
  - HALTED: in_ready=0, CC frozen, output entry still drains.
  - flush in the same cycle as the HLT/INS accept cancels the transition (stays RUN).
  - HALTED exits only via reset.
- Reset mid-operation drops any held entry immediately (out_valid=0 asynchronously).

Decomposition:
- Shared package y86_pkg: icode constants (IHALT..IPOPQ), ifun ALU/cond codes, stat codes (AOK/HLT/INS), RNONE, ALU control encodings.
- Sub-module: reuse the existing alu (control, A, B -> S, overflow, ans), instantiated once.
- The Cnd evaluator is a combinational function in the package. Keep the FSM, output register and CC register in exec_ctrl.

Test Plan:
- OPq add valA=0x7FFFFFFFFFFFFFFF, valB=1 -> next cycle out_valE=0x8000000000000000; CC ZF=0, SF=1, OF=1.
- OPq sub valA=5, valB=5, then jle back-to-back -> first valE=0, ZF=1; jle out_Cnd=1. Then cmovne dstE=3 -> out_Cnd=0, out_dstE=0xF.
- pushq valB=0x100 with out_ready=0 for 3 cycles -> out_valE=0xF8 held stable, in_ready=0, no second accept. Release -> drains, in_ready=1.
- OPq xor with cc_inhibit=1 -> out_valE computed, CC unchanged from reset (ZF=1, SF=0, OF=0).
- Accept irmovq with flush=1 same cycle -> out_valid stays 0. Flush with a held entry -> out_valid=0 next cycle.
- icode=0xC -> out_stat=INS, valE=0, state HALTED, in_ready=0 thereafter. Assert rst_n=0 -> out_valid=0 and CC reset immediately, RUN resumes.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage definitions: icodes, function codes, status, ALU controls.
// Also hosts the combinational branch/cmov condition evaluator.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] FADDQ = 4'h0;
  localparam logic [3:0] FSUBQ = 4'h1;
  localparam logic [3:0] FANDQ = 4'h2;
  localparam logic [3:0] FXORQ = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_INS = 2'd2
  } stat_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_ctrl_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] dst_e;
    logic       cnd;
    stat_t      stat;
  } em_ctl_t;

  function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | cc.zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = cc.zf;
      C_NE:    cond_eval = !cc.zf;
      C_GE:    cond_eval = !lt;
      C_G:     cond_eval = !lt && !cc.zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Decode->execute instruction handshake plus the E->M output entry and CC observation.
// master drives instructions and consumes the entry; slave is the execute controller.
interface exec_ctrl_if #(parameter int W = 64);

  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_icode;
  logic [3:0]   in_ifun;
  logic [W-1:0] in_valA;
  logic [W-1:0] in_valB;
  logic [W-1:0] in_valC;
  logic [3:0]   in_dstE;
  logic         flush;
  logic         cc_inhibit;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_icode;
  logic [W-1:0] out_valE;
  logic [W-1:0] out_valA;
  logic [3:0]   out_dstE;
  logic         out_Cnd;
  logic [1:0]   out_stat;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  modport master (
    output in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_dstE,
    output flush, cc_inhibit, out_ready,
    input  in_ready, out_valid, out_icode, out_valE, out_valA, out_dstE,
    input  out_Cnd, out_stat, cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_valA, in_valB, in_valC, in_dstE,
    input  flush, cc_inhibit, out_ready,
    output in_ready, out_valid, out_icode, out_valE, out_valA, out_dstE,
    output out_Cnd, out_stat, cc_zf, cc_sf, cc_of
  );

endinterface

// File: rtl/alu.sv
// Shared Y86-64 ALU: add, sub (B-A), and, xor with signed overflow; purely combinational.
// No state and no handshake; the caller decides when the result is consumed.
module alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  alu_ctrl_t    control,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         overflow
);

  always_comb begin
    s        = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        s        = a + b;
        overflow = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        s        = b - a;
        overflow = (b[W-1] != a[W-1]) && (s[W-1] != b[W-1]);
      end
      ALU_AND: s = a & b;
      ALU_XOR: s = a ^ b;
      default: s = '0;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Y86-64 execute controller: ALU sequencing, CC register, Cnd, single-entry E->M register; 1-cycle latency.
// Accepts when RUN and the entry is empty or draining; HALTED blocks input until reset while the entry drains.
module exec_ctrl
  import y86_pkg::*;
#(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = REG_NONE
) (
  input logic        clk,
  input logic        rst_n,
  exec_ctrl_if.slave bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t       state, state_nxt;
  cc_t          cc_q;
  logic         out_valid_q;
  em_ctl_t      em_q;
  logic [W-1:0] vale_q, vala_q;

  alu_ctrl_t    alu_ctl;
  logic [W-1:0] alu_a, alu_b, alu_s;
  logic         alu_ovf;
  logic         use_alu, is_cond, cnd, accept, cc_wr, in_ready;
  stat_t        stat;
  logic [W-1:0] vale;
  logic [3:0]   dste;

  always_comb begin
    alu_ctl = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    use_alu = 1'b1;
    is_cond = 1'b0;
    stat    = STAT_AOK;
    case (bus.in_icode)
      IHALT: begin
        use_alu = 1'b0;
        stat    = STAT_HLT;
      end
      INOP: use_alu = 1'b0;
      IRRMOVQ: begin
        alu_a   = bus.in_valA;
        is_cond = 1'b1;
        if (bus.in_ifun > C_G) stat = STAT_INS;
      end
      IIRMOVQ: alu_a = bus.in_valC;
      IRMMOVQ, IMRMOVQ: begin
        alu_a = bus.in_valC;
        alu_b = bus.in_valB;
      end
      IOPQ: begin
        alu_ctl = alu_ctrl_t'(bus.in_ifun[1:0]);
        alu_a   = bus.in_valA;
        alu_b   = bus.in_valB;
        if (bus.in_ifun > FXORQ) stat = STAT_INS;
      end
      IJXX: begin
        use_alu = 1'b0;
        is_cond = 1'b1;
        if (bus.in_ifun > C_G) stat = STAT_INS;
      end
      ICALL, IPUSHQ: begin
        alu_ctl = ALU_SUB;
        alu_a   = W'(8);
        alu_b   = bus.in_valB;
      end
      IRET, IPOPQ: begin
        alu_a = W'(8);
        alu_b = bus.in_valB;
      end
      default: begin
        use_alu = 1'b0;
        stat    = STAT_INS;
      end
    endcase
  end

  alu #(.W(W)) u_alu (
    .control (alu_ctl),
    .a       (alu_a),
    .b       (alu_b),
    .s       (alu_s),
    .overflow(alu_ovf)
  );

  // Cnd sees the flags already in the register, i.e. those of the previous OPq.
  assign cnd    = is_cond && (stat == STAT_AOK) && cond_eval(bus.in_ifun, cc_q);
  assign vale   = (use_alu && stat == STAT_AOK) ? alu_s : '0;
  assign dste   = (bus.in_icode == IRRMOVQ && !cnd) ? RNONE : bus.in_dstE;
  assign accept = bus.in_valid && in_ready && !bus.flush;
  assign cc_wr  = accept && (bus.in_icode == IOPQ) && (stat == STAT_AOK) && !bus.cc_inhibit;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      RUN: begin
        in_ready = !out_valid_q || bus.out_ready;
        if (bus.in_valid && in_ready && !bus.flush && stat != STAT_AOK) state_nxt = HALTED;
      end
      HALTED:  in_ready = 1'b0;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      em_q        <= '{icode: IHALT, dst_e: RNONE, cnd: 1'b0, stat: STAT_AOK};
      vale_q      <= '0;
      vala_q      <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      em_q        <= '{icode: bus.in_icode, dst_e: dste, cnd: cnd, stat: stat};
      vale_q      <= vale;
      vala_q      <= bus.in_valA;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cc_q <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    else if (cc_wr) cc_q <= '{zf: (alu_s == '0), sf: alu_s[W-1], of: alu_ovf};
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_icode = em_q.icode;
  assign bus.out_valE  = vale_q;
  assign bus.out_valA  = vala_q;
  assign bus.out_dstE  = em_q.dst_e;
  assign bus.out_Cnd   = em_q.cnd;
  assign bus.out_stat  = em_q.stat;
  assign bus.cc_zf     = cc_q.zf;
  assign bus.cc_sf     = cc_q.sf;
  assign bus.cc_of     = cc_q.of;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an arithmetic reference model of the execute stage.
module tb_exec_ctrl;

  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_ctrl_if #(.W(W)) bus ();

  exec_ctrl #(.W(W), .RNONE(4'hF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_halted, m_ov, m_cnd, m_zf, m_sf, m_of;
  logic [3:0]  m_icode, m_dst;
  logic [63:0] m_vale, m_vala;
  logic [1:0]  m_stat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic signed [65:0] sext(input logic [63:0] x);
    sext = $signed({{2{x[63]}}, x});
  endfunction

  task automatic model_reset();
    m_halted = 0; m_ov = 0; m_cnd = 0;
    m_zf = 1; m_sf = 0; m_of = 0;
    m_icode = 4'h0; m_dst = 4'hF; m_vale = '0; m_vala = '0; m_stat = 2'd0;
  endtask

  // One clock edge of the execute stage, written from the architectural rules.
  task automatic model_step();
    logic [3:0] ic, fn;
    logic [63:0] a, b, c, res;
    logic signed [65:0] wr;
    logic [1:0] st;
    bit rdy, acc, ins, is_cond, lt, cnd, of;
    if (!rst_n) return;
    ic = bus.in_icode; fn = bus.in_ifun;
    a = bus.in_valA; b = bus.in_valB; c = bus.in_valC;
    rdy = !m_halted && (!m_ov || bus.out_ready);
    acc = bus.in_valid && rdy && !bus.flush;
    ins = (ic > 4'hB) || (ic == 4'h6 && fn > 4'h3) || ((ic == 4'h2 || ic == 4'h7) && fn > 4'h6);
    st = ins ? 2'd2 : (ic == 4'h0 ? 2'd1 : 2'd0);
    is_cond = (ic == 4'h2) || (ic == 4'h7);
    lt = m_sf ^ m_of;
    case (fn)
      4'h0: cnd = 1;
      4'h1: cnd = lt || m_zf;
      4'h2: cnd = lt;
      4'h3: cnd = m_zf;
      4'h4: cnd = !m_zf;
      4'h5: cnd = !lt;
      4'h6: cnd = !lt && !m_zf;
      default: cnd = 0;
    endcase
    cnd = cnd && is_cond && !ins;
    res = '0; of = 0;
    if (!ins) begin
      case (ic)
        4'h2: res = a;
        4'h3: res = c;
        4'h4, 4'h5: res = b + c;
        4'h6: begin
          case (fn)
            4'h0: begin wr = sext(a) + sext(b); res = wr[63:0]; of = (wr != sext(res)); end
            4'h1: begin wr = sext(b) - sext(a); res = wr[63:0]; of = (wr != sext(res)); end
            4'h2: res = a & b;
            default: res = a ^ b;
          endcase
        end
        4'h8, 4'hA: res = b - 64'd8;
        4'h9, 4'hB: res = b + 64'd8;
        default: res = '0;
      endcase
    end
    if (bus.flush) m_ov = 0;
    else if (acc) begin
      m_ov = 1; m_icode = ic; m_vale = res; m_vala = a; m_cnd = cnd; m_stat = st;
      m_dst = (ic == 4'h2 && !cnd) ? 4'hF : bus.in_dstE;
    end else if (bus.out_ready) m_ov = 0;
    if (acc && ic == 4'h6 && !ins && !bus.cc_inhibit) begin
      m_zf = (res == 64'd0); m_sf = res[63]; m_of = of;
    end
    if (acc && st != 2'd0) m_halted = 1;
  endtask

  always @(negedge clk) begin
    check("in_ready", bus.in_ready, !m_halted && (!m_ov || bus.out_ready));
    check("out_valid", bus.out_valid, m_ov);
    check("cc_zf", bus.cc_zf, m_zf);
    check("cc_sf", bus.cc_sf, m_sf);
    check("cc_of", bus.cc_of, m_of);
    if (m_ov) begin
      check("out_icode", bus.out_icode, m_icode);
      check("out_valE", bus.out_valE, m_vale);
      check("out_valA", bus.out_valA, m_vala);
      check("out_dstE", bus.out_dstE, m_dst);
      check("out_Cnd", bus.out_Cnd, m_cnd);
      check("out_stat", bus.out_stat, m_stat);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input bit v, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [3:0] d);
    bus.in_valid = v; bus.in_icode = ic; bus.in_ifun = fn;
    bus.in_valA = a; bus.in_valB = b; bus.in_valC = c; bus.in_dstE = d;
  endtask

  function automatic logic [63:0] rand_val(input logic [63:0] other);
    case ($urandom_range(0, 5))
      0: rand_val = other;
      1: rand_val = 64'($urandom_range(0, 16));
      2: rand_val = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
      3: rand_val = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 2));
      default: rand_val = {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_inputs();
    logic [3:0] ic, fn;
    logic [63:0] a;
    ic = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
    if ($urandom_range(0, 9) == 0) fn = 4'($urandom_range(0, 15));
    else if (ic == 4'h6)            fn = 4'($urandom_range(0, 3));
    else                            fn = 4'($urandom_range(0, 6));
    a = rand_val(64'd0);
    set_in($urandom_range(0, 3) != 0, ic, fn, a, rand_val(a), rand_val(a), 4'($urandom_range(0, 15)));
    bus.flush      = ($urandom_range(0, 11) == 0);
    bus.cc_inhibit = ($urandom_range(0, 5) == 0);
    bus.out_ready  = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_valid", bus.out_valid, 1'b0);
    check("rst_async_zf", bus.cc_zf, 1'b1);
    check("rst_async_sf", bus.cc_sf, 1'b0);
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int halt_cnt;
    set_in(0, 4'h1, 4'h0, '0, '0, '0, 4'hF);
    bus.flush = 0; bus.cc_inhibit = 0; bus.out_ready = 1;
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_dstE", bus.out_dstE, 4'hF);
    check("reset_stat", bus.out_stat, 2'd0);
    check("reset_valE", bus.out_valE, 64'd0);
    check("reset_zf", bus.cc_zf, 1'b1);
    check("reset_in_ready", bus.in_ready, 1'b1);

    // xor with CC inhibited: result produced, flags untouched
    set_in(1, 4'h6, 4'h3, 64'hF0, 64'h0F, 64'd0, 4'h2);
    bus.cc_inhibit = 1;
    cyc();
    bus.cc_inhibit = 0;
    check("xor_inh_valE", bus.out_valE, 64'hFF);
    check("xor_inh_zf", bus.cc_zf, 1'b1);
    check("xor_inh_sf", bus.cc_sf, 1'b0);
    check("xor_inh_of", bus.cc_of, 1'b0);

    set_in(1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2);
    cyc();
    check("add_ovf_valE", bus.out_valE, 64'h8000_0000_0000_0000);
    check("add_ovf_zf", bus.cc_zf, 1'b0);
    check("add_ovf_sf", bus.cc_sf, 1'b1);
    check("add_ovf_of", bus.cc_of, 1'b1);

    set_in(1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2);
    cyc();
    check("sub_eq_valE", bus.out_valE, 64'd0);
    check("sub_eq_zf", bus.cc_zf, 1'b1);
    set_in(1, 4'h7, 4'h1, 64'd0, 64'd0, 64'h1234, 4'hF);
    cyc();
    check("jle_cnd", bus.out_Cnd, 1'b1);
    set_in(1, 4'h2, 4'h4, 64'd7, 64'd0, 64'd0, 4'h3);
    cyc();
    check("cmovne_cnd", bus.out_Cnd, 1'b0);
    check("cmovne_dstE", bus.out_dstE, 4'hF);

    set_in(1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
    cyc();
    check("push_valE", bus.out_valE, 64'hF8);
    bus.out_ready = 0;
    set_in(1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    repeat (3) begin
      cyc();
      check("push_hold_valE", bus.out_valE, 64'hF8);
      check("push_hold_icode", bus.out_icode, 4'hA);
      check("push_hold_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    #1;
    check("push_release_ready", bus.in_ready, 1'b1);
    cyc();
    check("push_drained", bus.out_valid, 1'b0);

    set_in(1, 4'h3, 4'h0, 64'd0, 64'd0, 64'h55, 4'h5);
    bus.flush = 1;
    cyc();
    check("flush_accept", bus.out_valid, 1'b0);
    bus.flush = 0;
    cyc();
    check("irmov_valE", bus.out_valE, 64'h55);
    bus.in_valid = 0; bus.out_ready = 0; bus.flush = 1;
    cyc();
    check("flush_held", bus.out_valid, 1'b0);
    bus.flush = 0; bus.out_ready = 1;

    set_in(1, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 4'h1);
    cyc();
    check("add_neg_sf", bus.cc_sf, 1'b1);
    set_in(1, 4'hC, 4'h0, 64'd9, 64'd9, 64'd9, 4'h1);
    cyc();
    check("ins_stat", bus.out_stat, 2'd2);
    check("ins_valE", bus.out_valE, 64'd0);
    bus.out_ready = 0;
    set_in(1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    #1;
    check("halted_ready", bus.in_ready, 1'b0);
    cyc();
    check("halted_hold_icode", bus.out_icode, 4'hC);
    check("halted_sf_frozen", bus.cc_sf, 1'b1);
    do_reset();
    #1;
    check("post_reset_ready", bus.in_ready, 1'b1);

    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cyc();
      if (m_halted) halt_cnt++;
      if (halt_cnt >= 4) begin
        halt_cnt = 0;
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
